// File: rtl/cfm_reset_pkg.sv
// Shared definitions for the reset sequencer.
// Contents:
//   seq_state_t   - sequencer FSM encoding, also driven out on the state port
//   LOCK_CNT_MAX  - saturation value of the lock-loss event counter
package cfm_reset_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_DELAY     = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_t;

    localparam logic [7:0] LOCK_CNT_MAX = 8'd255;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low clear, both flops go to 0
//   d     - asynchronous input
//   q     - synchronised output, two clk edges of latency
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer placed between the PLL and the core(s).
// Qualifies PLL lock over LOCK_WINDOW consecutive synchronised samples,
// holds reset for RELEASE_DELAY cycles, then releases STAGES reset domains
// one by one, STAGE_GAP cycles apart. Lock loss sends it back to lock
// qualification; a soft request restarts the delay without requalifying.
// Ports:
//   clk_core        - core clock (PLL output)
//   reset_n         - asynchronous active-low reset
//   pll_locked      - raw PLL lock, asynchronous to clk_core
//   soft_req        - single-cycle soft reset request
//   stage_reset_n   - per-domain active-low resets, bit 0 released first
//   ready           - all stages released
//   state           - FSM state (0 WAIT_LOCK, 1 DELAY, 2 RELEASE, 3 RUN)
//   lock_lost_count - saturating count of lock losses seen in RUN
module reset_sequencer
    import cfm_reset_pkg::*;
#(
    parameter int LOCK_WINDOW   = 4,
    parameter int RELEASE_DELAY = 128,
    parameter int STAGES        = 2,
    parameter int STAGE_GAP     = 16
) (
    input  logic              clk_core,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              soft_req,
    output logic [STAGES-1:0] stage_reset_n,
    output logic              ready,
    output logic [1:0]        state,
    output logic [7:0]        lock_lost_count
);

    localparam int CW = $clog2(RELEASE_DELAY) + 1;
    localparam int GW = $clog2(STAGE_GAP) + 1;
    localparam int PW = $clog2(STAGES) + 1;

    logic                   sync_locked;
    seq_state_t             state_reg, state_next;
    logic [LOCK_WINDOW-1:0] window_reg, window_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [GW-1:0]          gap_reg, gap_next;
    logic [PW-1:0]          ptr_reg, ptr_next;
    logic [STAGES-1:0]      stage_reg, stage_next;
    logic                   ready_reg, ready_next;
    logic [7:0]             count_reg, count_next;
    logic [STAGES-1:0]      ptr_mask;

    sync2 u_lock_sync (
        .clk   (clk_core),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (sync_locked)
    );

    // One-hot decode of the stage pointer: the bit to release next.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_ptr_mask
            assign ptr_mask[gi] = (ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_WAIT_LOCK;
            window_reg <= '0;
            cnt_reg    <= '0;
            gap_reg    <= '0;
            ptr_reg    <= '0;
            stage_reg  <= '0;
            ready_reg  <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            window_reg <= window_next;
            cnt_reg    <= cnt_next;
            gap_reg    <= gap_next;
            ptr_reg    <= ptr_next;
            stage_reg  <= stage_next;
            ready_reg  <= ready_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        // The lock window keeps sampling in every state; the cast keeps the
        // youngest LOCK_WINDOW bits so LOCK_WINDOW==1 needs no special case.
        window_next = LOCK_WINDOW'({window_reg, sync_locked});
        cnt_next    = cnt_reg;
        gap_next    = gap_reg;
        ptr_next    = ptr_reg;
        stage_next  = stage_reg;
        ready_next  = ready_reg;
        count_next  = count_reg;

        if (state_reg == ST_WAIT_LOCK) begin
            // soft_req is deliberately ignored while waiting for lock.
            if (&window_reg) begin
                state_next = ST_DELAY;
                cnt_next   = '0;
            end
        end else if (!sync_locked) begin
            // Lock loss outranks a coincident soft request.
            state_next  = ST_WAIT_LOCK;
            window_next = '0;
            cnt_next    = '0;
            gap_next    = '0;
            ptr_next    = '0;
            stage_next  = '0;
            ready_next  = 1'b0;
            if (state_reg == ST_RUN && count_reg != LOCK_CNT_MAX) begin
                count_next = count_reg + 8'd1;
            end
        end else if (soft_req) begin
            // Lock is still good, so skip requalification.
            state_next = ST_DELAY;
            cnt_next   = '0;
            gap_next   = '0;
            ptr_next   = '0;
            stage_next = '0;
            ready_next = 1'b0;
        end else begin
            case (state_reg)
                ST_DELAY: begin
                    if (cnt_reg == CW'(RELEASE_DELAY - 1)) begin
                        stage_next = stage_reg | STAGES'(1);
                        gap_next   = '0;
                        ptr_next   = PW'(1);
                        if (STAGES == 1) begin
                            state_next = ST_RUN;
                            ready_next = 1'b1;
                        end else begin
                            state_next = ST_RELEASE;
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (gap_reg == GW'(STAGE_GAP - 1)) begin
                        stage_next = stage_reg | ptr_mask;
                        gap_next   = '0;
                        if (ptr_reg == PW'(STAGES - 1)) begin
                            state_next = ST_RUN;
                            ready_next = 1'b1;
                        end else begin
                            ptr_next = ptr_reg + PW'(1);
                        end
                    end else begin
                        gap_next = gap_reg + GW'(1);
                    end
                end
                default: begin
                    // ST_RUN: everything stays released.
                end
            endcase
        end
    end

    assign stage_reset_n   = stage_reg;
    assign ready           = ready_reg;
    assign state           = state_reg;
    assign lock_lost_count = count_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int LW = 4;
    localparam int RD = 8;
    localparam int NS = 2;
    localparam int SG = 3;

    logic          clk_core   = 1'b0;
    logic          reset_n    = 1'b0;
    logic          pll_locked = 1'b0;
    logic          soft_req   = 1'b0;
    logic [NS-1:0] stage_reset_n;
    logic          ready;
    logic [1:0]    state;
    logic [7:0]    lock_lost_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: lock history, run length of good samples, and time
    // since the current sequence started; outputs derived arithmetically.
    int h1, h2, run, m_t, m_cnt;
    bit m_active;

    always #5 clk_core = ~clk_core;

    reset_sequencer #(
        .LOCK_WINDOW   (LW),
        .RELEASE_DELAY (RD),
        .STAGES        (NS),
        .STAGE_GAP     (SG)
    ) dut (
        .clk_core        (clk_core),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .soft_req        (soft_req),
        .stage_reset_n   (stage_reset_n),
        .ready           (ready),
        .state           (state),
        .lock_lost_count (lock_lost_count)
    );

    function automatic int released(input int t);
        int k;
        if (t < RD) return 0;
        k = 1 + (t - RD) / SG;
        return (k > NS) ? NS : k;
    endfunction

    function automatic logic [12:0] exp_bundle();
        int k;
        logic [1:0] st;
        logic [NS-1:0] stg;
        logic rdy;
        k   = m_active ? released(m_t) : 0;
        st  = !m_active ? 2'd0 : (k == 0 ? 2'd1 : (k < NS ? 2'd2 : 2'd3));
        stg = NS'((1 << k) - 1);
        rdy = m_active && (k == NS);
        return {st, stg, rdy, 8'(m_cnt)};
    endfunction

    function automatic logic [12:0] got_bundle();
        return {state, stage_reset_n, ready, lock_lost_count};
    endfunction

    function automatic bit model_in_run();
        return m_active && released(m_t) == NS;
    endfunction

    task automatic model_reset();
        h1 = 0; h2 = 0; run = 0; m_t = 0; m_cnt = 0; m_active = 0;
    endtask

    task automatic model_edge(input bit p, input bit s);
        int sl;
        bit full;
        sl   = h2;
        h2   = h1;
        h1   = p;
        full = (run >= LW);
        run  = sl ? ((run < 1000) ? run + 1 : run) : 0;
        if (!m_active) begin
            if (full) begin
                m_active = 1;
                m_t      = 0;
            end
        end else if (sl == 0) begin
            if (released(m_t) == NS && m_cnt < 255) m_cnt++;
            m_active = 0;
            m_t      = 0;
        end else if (s) begin
            m_t = 0;
        end else if (m_t < 100000) begin
            m_t++;
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then return 1 time unit later, away from the edge.
    task automatic step();
        @(posedge clk_core);
        if (!reset_n) model_reset();
        else model_edge(pll_locked, soft_req);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        soft_req   = 1'b0;
        model_reset();
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic bring_to_run();
        pll_locked = 1'b1;
        soft_req   = 1'b0;
        for (int i = 0; i < 200 && !model_in_run(); i++) step();
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL reach_run state=%0d required=3", state);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (got_bundle() !== 13'd0) begin
            failures++;
            $display("FAIL reset_async got=%b required=%b", got_bundle(), 13'd0);
        end
        do_reset();
        checks++;
        if (got_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL reset_hold got=%b required=%b", got_bundle(), exp_bundle());
        end
        $display("tb: reset scenario done");
    endtask

    task automatic test_bringup();
        do_reset();
        pll_locked = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            step();
            checks++;
            if (got_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL bringup E%0d got=%b required=%b", e, got_bundle(), exp_bundle());
            end
            if (e == 5 || e == 6) begin
                checks++;
                if (state !== ((e == 6) ? 2'd1 : 2'd0)) begin
                    failures++;
                    $display("FAIL bringup_delay E%0d state=%0d", e, state);
                end
            end
            if (e == 13 || e == 14) begin
                checks++;
                if (stage_reset_n !== ((e == 14) ? 2'b01 : 2'b00)) begin
                    failures++;
                    $display("FAIL bringup_stage0 E%0d stage=%b", e, stage_reset_n);
                end
            end
            if (e == 17) begin
                checks++;
                if ({stage_reset_n, ready, state} !== {2'b11, 1'b1, 2'd3}) begin
                    failures++;
                    $display("FAIL bringup_run E17 stage=%b ready=%b state=%0d required 11/1/3",
                             stage_reset_n, ready, state);
                end
            end
        end
        $display("tb: bring-up scenario done");
    endtask

    task automatic test_glitch();
        do_reset();
        for (int e = 0; e <= 25; e++) begin
            pll_locked = (e == 3) ? 1'b0 : 1'b1;
            step();
            checks++;
            if (got_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL glitch E%0d got=%b required=%b", e, got_bundle(), exp_bundle());
            end
            if (e == 6 || e == 9 || e == 10) begin
                checks++;
                if (state !== ((e == 10) ? 2'd1 : 2'd0)) begin
                    failures++;
                    $display("FAIL glitch_state E%0d state=%0d", e, state);
                end
            end
        end
        $display("tb: lock glitch scenario done");
    endtask

    task automatic test_lock_loss_run();
        int c0;
        bring_to_run();
        c0 = m_cnt;
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL loss_early state=%0d required=3", state);
        end
        step();
        checks++;
        if ({state, stage_reset_n, ready, lock_lost_count} !== {2'd0, 2'b00, 1'b0, 8'(c0 + 1)}) begin
            failures++;
            $display("FAIL loss_run got=%b required state0 stage00 ready0 count=%0d",
                     got_bundle(), c0 + 1);
        end
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (got_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL loss_reseq cyc=%0d got=%b required=%b", i, got_bundle(), exp_bundle());
            end
        end
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL loss_rerun state=%0d required=3", state);
        end
        $display("tb: lock loss in RUN scenario done");
    endtask

    task automatic test_soft_run();
        int c0;
        bring_to_run();
        c0 = m_cnt;
        soft_req = 1'b1;
        step();
        soft_req = 1'b0;
        checks++;
        if ({state, stage_reset_n} !== {2'd1, 2'b00}) begin
            failures++;
            $display("FAIL soft_enter state=%0d stage=%b required 1/00", state, stage_reset_n);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (got_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL soft_seq k=%0d got=%b required=%b", k, got_bundle(), exp_bundle());
            end
            if (k == 7 || k == 8 || k == 10 || k == 11) begin
                checks++;
                if (stage_reset_n !== ((k < 8) ? 2'b00 : (k < 11) ? 2'b01 : 2'b11)) begin
                    failures++;
                    $display("FAIL soft_stage k=%0d stage=%b", k, stage_reset_n);
                end
            end
        end
        checks++;
        if (lock_lost_count !== 8'(c0)) begin
            failures++;
            $display("FAIL soft_count got=%0d required=%0d", lock_lost_count, c0);
        end
        $display("tb: soft request scenario done");
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) begin
            bring_to_run();
            pll_locked = 1'b0;
            step();
            pll_locked = 1'b1;
            step();
            step();
            checks++;
            if (got_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL sat_iter n=%0d got=%b required=%b", n, got_bundle(), exp_bundle());
            end
        end
        checks++;
        if (lock_lost_count !== 8'd255) begin
            failures++;
            $display("FAIL sat_count got=%0d required=255", lock_lost_count);
        end
        $display("tb: saturation scenario done");
    endtask

    task automatic test_priority();
        bring_to_run();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        soft_req = 1'b1;
        step();
        soft_req = 1'b0;
        checks++;
        if (state !== 2'd0 || got_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL priority state=%0d required=0 got=%b model=%b", state, got_bundle(), exp_bundle());
        end
        $display("tb: loss-vs-soft priority scenario done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            pll_locked = ($urandom_range(0, 49) != 0);
            soft_req   = ($urandom_range(0, 29) == 0);
            step();
            checks++;
            if (got_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b required=%b", i, got_bundle(), exp_bundle());
            end
        end
        soft_req = 1'b0;
        $display("tb: random scenario done");
    endtask

    task automatic test_async_reset();
        do_reset();
        pll_locked = 1'b1;
        for (int i = 0; i < 200 && !(m_active && released(m_t) == 1); i++) step();
        checks++;
        if (state !== 2'd2) begin
            failures++;
            $display("FAIL async_pre state=%0d required=2", state);
        end
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (got_bundle() !== 13'd0) begin
            failures++;
            $display("FAIL async_now got=%b required=%b", got_bundle(), 13'd0);
        end
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            checks++;
            if (got_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL async_restart cyc=%0d got=%b required=%b", i, got_bundle(), exp_bundle());
            end
        end
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL async_rerun state=%0d required=3", state);
        end
        $display("tb: async reset scenario done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bringup();
        test_glitch();
        test_lock_loss_run();
        test_soft_run();
        test_saturation();
        test_priority();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
